// File: rtl/ui_input_debouncer_if.sv
// Pin-side and controller-side signals of the UI input debouncer.
// master drives the raw pins and event clears; slave is the debouncer itself.
interface ui_input_debouncer_if #(
    parameter int NKEYS = 4,
    parameter int NSW   = 10
);
    logic [NKEYS-1:0] rawKeys;
    logic [NSW-1:0]   rawSwitches;
    logic             evtClr;
    logic [NKEYS-1:0] evtClrMask;
    logic [NKEYS-1:0] KEYS;
    logic [NSW-1:0]   SWITCHES;
    logic [NKEYS-1:0] keyPress;
    logic [NKEYS-1:0] keyEvent;

    modport master (
        output rawKeys, rawSwitches, evtClr, evtClrMask,
        input  KEYS, SWITCHES, keyPress, keyEvent
    );

    modport slave (
        input  rawKeys, rawSwitches, evtClr, evtClrMask,
        output KEYS, SWITCHES, keyPress, keyEvent
    );
endinterface

// File: rtl/ui_input_debouncer.sv
// Synchronizes and debounces board keys/switches; keys come out as pressed = 1.
// Define UI_KEY_EVENT_EN to build the key press pulse and sticky event flags.
module ui_input_debouncer #(
    parameter int NKEYS           = 4,
    parameter int NSW             = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    ui_input_debouncer_if.slave     bus
);
    localparam int NB = NKEYS + NSW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0] key_sync [SYNC_STAGES];
    logic [NSW-1:0]   sw_sync  [SYNC_STAGES];
    logic [NB-1:0]    lvl_sync;
    logic [NB-1:0]    lvl;
    logic [CW-1:0]    cnt [NB];

    // Key chains reset to the released (high) pin level so no false press appears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                key_sync[k] <= '1;
                sw_sync[k]  <= '0;
            end
        end else begin
            key_sync[0] <= bus.rawKeys;
            sw_sync[0]  <= bus.rawSwitches;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                key_sync[k] <= key_sync[k-1];
                sw_sync[k]  <= sw_sync[k-1];
            end
        end
    end

    assign lvl_sync = {~key_sync[SYNC_STAGES-1], sw_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (lvl_sync[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    lvl[i] <= lvl_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.KEYS     = lvl[NB-1:NSW];
    assign bus.SWITCHES = lvl[NSW-1:0];

`ifdef UI_KEY_EVENT_EN
    logic [NKEYS-1:0] key_d;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_event;

    // A press pulse in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_d     <= '0;
            key_press <= '0;
            key_event <= '0;
        end else begin
            key_d     <= lvl[NB-1:NSW];
            key_press <= lvl[NB-1:NSW] & ~key_d;
            key_event <= (key_event & ~({NKEYS{bus.evtClr}} & bus.evtClrMask)) | key_press;
        end
    end

    assign bus.keyPress = key_press;
    assign bus.keyEvent = key_event;
`else
    logic unused_evt;
    assign unused_evt   = &{1'b0, bus.evtClr, bus.evtClrMask};
    assign bus.keyPress = '0;
    assign bus.keyEvent = '0;
`endif

endmodule

// File: tb/tb_ui_input_debouncer.sv
// Bench for ui_input_debouncer: directed scenarios plus random pin activity
// checked against a sample-window reference model.
module tb_ui_input_debouncer;
    localparam int NK = 4;
    localparam int NS = 10;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int NB = NK + NS;
    localparam int HL = SS + DC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ui_input_debouncer_if #(.NKEYS(NK), .NSW(NS)) bus ();

    ui_input_debouncer #(
        .NKEYS(NK), .NSW(NS), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Model: an output bit flips once the last DC synchronized samples all disagree with it.
    logic [NB-1:0] hist [HL];
    logic [NB-1:0] m_out;
    logic [NK-1:0] m_out_d, m_kp, m_ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < HL; j++) hist[j] = '0;
            m_out = '0; m_out_d = '0; m_kp = '0; m_ev = '0;
        end else begin
            logic [NK-1:0] kp_n;
            logic [NK-1:0] ev_n;
            logic          flip;
            kp_n = m_out[NB-1:NS] & ~m_out_d;
            ev_n = (m_ev & ~(bus.evtClr ? bus.evtClrMask : 4'h0)) | m_kp;
            m_out_d = m_out[NB-1:NS];
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {~bus.rawKeys, bus.rawSwitches};
            for (int i = 0; i < NB; i++) begin
                flip = 1'b1;
                for (int j = SS; j < HL; j++) if (hist[j][i] == m_out[i]) flip = 1'b0;
                if (flip) m_out[i] = ~m_out[i];
            end
            m_kp = kp_n;
            m_ev = ev_n;
        end
    end

    function automatic logic [21:0] model_vec();
`ifdef UI_KEY_EVENT_EN
        return {m_out, m_kp, m_ev};
`else
        return {m_out, 4'h0, 4'h0};
`endif
    endfunction

    logic [21:0] dut_vec;
    assign dut_vec = {bus.KEYS, bus.SWITCHES, bus.keyPress, bus.keyEvent};

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rawKeys = 4'hF; bus.rawSwitches = '0; bus.evtClr = 1'b0; bus.evtClrMask = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 22'h0) begin
                errors++;
                $display("FAIL reset_hold: got %h want 0", dut_vec);
            end
            bus.rawKeys = 4'($urandom);
            bus.rawSwitches = 10'($urandom);
        end
        @(negedge clk);
        bus.rawKeys = 4'hF; bus.rawSwitches = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 22'h0 || model_vec() !== 22'h0) begin
                errors++;
                $display("FAIL reset_idle: got %h want 0", dut_vec);
            end
        end
    endtask

    task automatic test_switch_latency();
        @(negedge clk);
        bus.rawSwitches = 10'h2A5;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.SWITCHES !== ((k >= 6) ? 10'h2A5 : 10'h0) || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL sw_latency edge %0d: got %h want %h", k, bus.SWITCHES,
                         (k >= 6) ? 10'h2A5 : 10'h0);
            end
        end
        @(negedge clk);
        bus.rawSwitches = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL sw_release: got %h want %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_short_pulse();
        @(negedge clk);
        bus.rawKeys = 4'hE;
        repeat (3) @(negedge clk);
        bus.rawKeys = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.KEYS !== 4'h0 || bus.keyPress !== 4'h0 || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL short_pulse: keys %h press %h want 0", bus.KEYS, bus.keyPress);
            end
        end
        @(negedge clk);
        bus.rawKeys = 4'hE;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.KEYS[0] !== (k >= 6) || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL key0_press edge %0d: got %b want %b", k, bus.KEYS[0], k >= 6);
            end
        end
        @(negedge clk);
        bus.rawKeys = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL key0_release: got %h want %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b0000_0101;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            bus.rawKeys[1] = (k <= 8) ? pat[k-1] : 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus.KEYS[1] !== (k >= 9) || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL bounce edge %0d: got %b want %b", k, bus.KEYS[1], k >= 9);
            end
        end
        @(negedge clk);
        bus.rawKeys = 4'hF;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.KEYS !== 4'h0) begin
            errors++;
            $display("FAIL bounce_release: got %h want 0", bus.KEYS);
        end
    endtask

`ifdef UI_KEY_EVENT_EN
    task automatic test_key_event();
        @(negedge clk);
        bus.evtClr = 1'b1; bus.evtClrMask = 4'hF;
        @(negedge clk);
        bus.evtClr = 1'b0;
        bus.rawKeys = 4'hB;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.keyPress !== ((k == 7) ? 4'b0100 : 4'b0000) || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL key_press edge %0d: got %b", k, bus.keyPress);
            end
        end
        checks++;
        if (bus.keyEvent !== 4'b0100) begin
            errors++;
            $display("FAIL key_event_set: got %b want 0100", bus.keyEvent);
        end
        @(negedge clk);
        bus.rawKeys = 4'hF;
        repeat (8) @(negedge clk);
        bus.rawKeys = 4'hB;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (bus.keyPress !== 4'b0100) begin
            errors++;
            $display("FAIL key_press_again: got %b want 0100", bus.keyPress);
        end
        @(negedge clk);
        bus.evtClr = 1'b1; bus.evtClrMask = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (bus.keyEvent !== 4'b0100 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL set_wins: got %b want 0100", bus.keyEvent);
        end
        @(negedge clk);
        bus.evtClr = 1'b0;
        repeat (3) @(negedge clk);
        bus.evtClr = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.keyEvent !== 4'b0000) begin
            errors++;
            $display("FAIL lone_clear: got %b want 0000", bus.keyEvent);
        end
        @(negedge clk);
        bus.evtClr = 1'b0;
        bus.rawKeys = 4'hF;
        repeat (10) @(negedge clk);
    endtask
`else
    task automatic test_key_event();
        @(negedge clk);
        bus.evtClr = 1'b1; bus.evtClrMask = 4'hF;
        bus.rawKeys = 4'hB;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (bus.keyPress !== 4'h0 || bus.keyEvent !== 4'h0 || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL evt_disabled: press %b event %b want 0", bus.keyPress, bus.keyEvent);
            end
        end
        bus.evtClr = 1'b0;
        bus.rawKeys = 4'hF;
        repeat (10) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_count();
        @(negedge clk);
        bus.rawSwitches = 10'h001;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.SWITCHES !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", bus.SWITCHES);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.SWITCHES !== 10'h0) begin
                errors++;
                $display("FAIL reset_mid_hold: got %h want 0", bus.SWITCHES);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.SWITCHES !== ((k >= 6) ? 10'h001 : 10'h0) || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL redebounce edge %0d: got %h", k, bus.SWITCHES);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.SWITCHES !== 10'h0 || bus.KEYS !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got %h want 0", bus.SWITCHES);
        end
        @(negedge clk);
        bus.rawSwitches = '0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        for (int s = 0; s < 300; s++) begin
            int hold;
            hold = int'($urandom_range(1, 7));
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random seg %0d: got %h want %h", s, dut_vec, model_vec());
            end
            if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            bus.rawKeys     = 4'($urandom);
            bus.rawSwitches = 10'($urandom);
            bus.evtClr      = ($urandom_range(0, 5) == 0);
            bus.evtClrMask  = 4'($urandom);
            for (int c = 1; c < hold; c++) begin
                @(negedge clk);
                rst_n = 1'b1;
                bus.evtClr = 1'b0;
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL random seg %0d cyc %0d: got %h want %h", s, c, dut_vec, model_vec());
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.evtClr = 1'b0;
    endtask

    initial begin
        bus.rawKeys = 4'hF; bus.rawSwitches = '0; bus.evtClr = 1'b0; bus.evtClrMask = '0;
        test_reset();
        test_switch_latency();
        test_short_pulse();
        test_bounce();
        test_key_event();
        test_reset_mid_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
